// File: rtl/matrix3x3_mac_engine.sv
// 3x3 unsigned matrix multiply, C = A x B, through one shared
// two-stage multiply-accumulate pipeline (27 products per job).
module matrix3x3_mac_engine #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a11,
  input  logic [DATA_W-1:0] a12,
  input  logic [DATA_W-1:0] a13,
  input  logic [DATA_W-1:0] a21,
  input  logic [DATA_W-1:0] a22,
  input  logic [DATA_W-1:0] a23,
  input  logic [DATA_W-1:0] a31,
  input  logic [DATA_W-1:0] a32,
  input  logic [DATA_W-1:0] a33,
  input  logic [DATA_W-1:0] b11,
  input  logic [DATA_W-1:0] b12,
  input  logic [DATA_W-1:0] b13,
  input  logic [DATA_W-1:0] b21,
  input  logic [DATA_W-1:0] b22,
  input  logic [DATA_W-1:0] b23,
  input  logic [DATA_W-1:0] b31,
  input  logic [DATA_W-1:0] b32,
  input  logic [DATA_W-1:0] b33,
  output logic [ACC_W-1:0]  c11,
  output logic [ACC_W-1:0]  c12,
  output logic [ACC_W-1:0]  c13,
  output logic [ACC_W-1:0]  c21,
  output logic [ACC_W-1:0]  c22,
  output logic [ACC_W-1:0]  c23,
  output logic [ACC_W-1:0]  c31,
  output logic [ACC_W-1:0]  c32,
  output logic [ACC_W-1:0]  c33,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [9*DATA_W-1:0] w_ain;
  logic [9*DATA_W-1:0] w_bin;
  logic [9*DATA_W-1:0] r_a;
  logic [9*DATA_W-1:0] r_b;

  logic [1:0] r_row;
  logic [1:0] r_col;
  logic [1:0] r_t;

  logic              w_accept;
  logic              w_issue;
  logic              w_last_issue;
  logic [3:0]        w_ai;
  logic [3:0]        w_bi;
  logic [3:0]        w_e;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;

  logic [2*DATA_W-1:0] w_prod;

  logic                r_s1_v;
  logic [3:0]          r_s1_e;
  logic                r_s1_first;
  logic                r_s1_last;
  logic [2*DATA_W-1:0] r_s1_p;

  logic [ACC_W-1:0]   w_p_ext;
  logic [ACC_W-1:0]   w_sum;
  logic [ACC_W-1:0]   r_acc;
  logic [9*ACC_W-1:0] r_c;

  assign w_ain = {a33, a32, a31, a23, a22, a21, a13, a12, a11};
  assign w_bin = {b33, b32, b31, b23, b22, b21, b13, b12, b11};

  assign busy = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done = (r_state == S_DONE);

  assign w_accept = start &&
    ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_issue = (r_state == S_RUN);
  assign w_last_issue = (r_row == 2'd2) &&
    (r_col == 2'd2) && (r_t == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_RUN;
      S_RUN:   if (w_last_issue) w_next = S_DRAIN;
      S_DRAIN: begin
        if (r_s1_v && r_s1_last && (r_s1_e == 4'd8))
          w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operands are only captured on the accepting edge.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= w_ain;
      r_b <= w_bin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_row <= '0;
      r_col <= '0;
      r_t   <= '0;
    end else if (w_issue) begin
      if (r_t != 2'd2) begin
        r_t <= r_t + 2'd1;
      end else begin
        r_t <= '0;
        if (r_col != 2'd2) begin
          r_col <= r_col + 2'd1;
        end else begin
          r_col <= '0;
          r_row <= r_row + 2'd1;
        end
      end
    end
  end

  assign w_ai = {2'b00, r_row} * 4'd3 + {2'b00, r_t};
  assign w_bi = {2'b00, r_t} * 4'd3 + {2'b00, r_col};
  assign w_e  = {2'b00, r_row} * 4'd3 + {2'b00, r_col};
  assign w_a  = r_a[w_ai*DATA_W +: DATA_W];
  assign w_b  = r_b[w_bi*DATA_W +: DATA_W];

  assign w_prod = {{DATA_W{1'b0}}, w_a} *
                  {{DATA_W{1'b0}}, w_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v     <= 1'b0;
      r_s1_e     <= '0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_p     <= '0;
    end else begin
      r_s1_v <= w_issue;
      if (w_issue) begin
        r_s1_e     <= w_e;
        r_s1_first <= (r_t == 2'd0);
        r_s1_last  <= (r_t == 2'd2);
        r_s1_p     <= w_prod;
      end
    end
  end

  assign w_p_ext = ACC_W'(r_s1_p);
  assign w_sum   = r_acc + w_p_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_c   <= '0;
    end else if (r_s1_v) begin
      if (r_s1_first) r_acc <= w_p_ext;
      else            r_acc <= w_sum;
      if (r_s1_last)
        r_c[r_s1_e*ACC_W +: ACC_W] <= w_sum;
    end
  end

  assign c11 = r_c[0*ACC_W +: ACC_W];
  assign c12 = r_c[1*ACC_W +: ACC_W];
  assign c13 = r_c[2*ACC_W +: ACC_W];
  assign c21 = r_c[3*ACC_W +: ACC_W];
  assign c22 = r_c[4*ACC_W +: ACC_W];
  assign c23 = r_c[5*ACC_W +: ACC_W];
  assign c31 = r_c[6*ACC_W +: ACC_W];
  assign c32 = r_c[7*ACC_W +: ACC_W];
  assign c33 = r_c[8*ACC_W +: ACC_W];

endmodule

// File: tb/tb_matrix3x3_mac_engine.sv
// Bench for matrix3x3_mac_engine: directed and random jobs
// checked edge by edge against a plain matrix-product model.
module tb_matrix3x3_mac_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  av [9];
  logic [7:0]  bv [9];
  logic [15:0] cv [9];
  logic        done;
  logic        busy;

  int n_cmp;
  int n_bad;
  int ta [9];
  int tb [9];
  int texp [9];
  int tprev [9];

  matrix3x3_mac_engine #(.DATA_W(8), .ACC_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a11(av[0]), .a12(av[1]), .a13(av[2]),
    .a21(av[3]), .a22(av[4]), .a23(av[5]),
    .a31(av[6]), .a32(av[7]), .a33(av[8]),
    .b11(bv[0]), .b12(bv[1]), .b13(bv[2]),
    .b21(bv[3]), .b22(bv[4]), .b23(bv[5]),
    .b31(bv[6]), .b32(bv[7]), .b33(bv[8]),
    .c11(cv[0]), .c12(cv[1]), .c13(cv[2]),
    .c21(cv[3]), .c22(cv[4]), .c23(cv[5]),
    .c31(cv[6]), .c32(cv[7]), .c33(cv[8]),
    .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic void model();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        int s;
        s = 0;
        for (int t = 0; t < 3; t++)
          s += ta[i*3+t] * tb[t*3+j];
        texp[i*3+j] = s & 32'hFFFF;
      end
  endfunction

  task automatic run_job(input bit hold, input string tag);
    model();
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      av[i] = 8'(ta[i]);
      bv[i] = 8'(tb[i]);
    end
    start = 1'b1;
    @(posedge clk); #1;
    chk({tag, " busy@E0"}, 32'(busy), 1);
    chk({tag, " done@E0"}, 32'(done), 0);
    if (!hold) start = 1'b0;
    for (int n = 1; n <= 28; n++) begin
      @(posedge clk); #1;
      if (hold && n == 5)
        for (int i = 0; i < 9; i++) begin
          av[i] = 8'd0;
          bv[i] = 8'd0;
        end
      chk($sformatf("%s busy@E%0d", tag, n),
          32'(busy), 32'(n < 28));
      chk($sformatf("%s done@E%0d", tag, n),
          32'(done), 32'(n == 28));
      for (int e = 0; e < 9; e++)
        chk($sformatf("%s c[%0d]@E%0d", tag, e, n), 32'(cv[e]),
            (n >= 3*e + 4) ? texp[e] : tprev[e]);
    end
    tprev = texp;
  endtask

  task automatic set_mixed();
    for (int i = 0; i < 9; i++) begin
      ta[i] = i + 1;
      tb[i] = 9 - i;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      av[i] = 8'd0;
      bv[i] = 8'd0;
      tprev[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst done", 32'(done), 0);
    chk("rst busy", 32'(busy), 0);
    for (int e = 0; e < 9; e++)
      chk($sformatf("rst c[%0d]", e), 32'(cv[e]), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      ta[i] = (i % 4 == 0) ? 1 : 0;
      tb[i] = i + 1;
    end
    run_job(1'b0, "ident");
    for (int i = 0; i < 9; i++) begin
      ta[i] = 1;
      tb[i] = 1;
    end
    run_job(1'b0, "b2b");

    set_mixed();
    run_job(1'b0, "mixed");
    chk("mixed c11 const", 32'(cv[0]), 30);
    chk("mixed c33 const", 32'(cv[8]), 90);

    for (int i = 0; i < 9; i++) begin
      ta[i] = 255;
      tb[i] = 255;
    end
    run_job(1'b0, "wrap");
    chk("wrap c22 const", 32'(cv[4]), 64003);

    set_mixed();
    run_job(1'b1, "hold");
    for (int i = 0; i < 9; i++) begin
      ta[i] = 0;
      tb[i] = 0;
    end
    run_job(1'b0, "hold2");

    set_mixed();
    run_job(1'b0, "pre_rst");
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      chk($sformatf("midrst done@%0d", n), 32'(done), 0);
      chk($sformatf("midrst busy@%0d", n), 32'(busy), 0);
      for (int e = 0; e < 9; e++)
        chk($sformatf("midrst c[%0d]@%0d", e, n), 32'(cv[e]), 0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 9; i++) tprev[i] = 0;
    set_mixed();
    run_job(1'b0, "post_rst");

    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 9; i++) begin
        ta[i] = int'($urandom_range(0, 255));
        tb[i] = int'($urandom_range(0, 255));
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_job(1'b0, $sformatf("rand%0d", j));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
